// File: rtl/ctrl_code_gen_s4_if.sv
// ---------------------------------------------------------------------------
// ctrl_code_gen_s4_if
// Bundles the stage-3 -> stage-4 control handshake of the pipelined core.
//   master : drives the stage-3 slot (in_valid, opcode, flags, *_i controls),
//            stall and flush; observes the stage-4 strobes.
//   slave  : the stage-4 control code generator.
// Parameter FLAG_CNT sets the width of the live flag vector.
// ---------------------------------------------------------------------------
interface ctrl_code_gen_s4_if #(
  parameter int FLAG_CNT = 8
);
  // slot from stage 3
  logic                in_valid;
  logic [7:0]          opcode;
  logic [FLAG_CNT-1:0] flags;
  logic                wr_i;
  logic                xrn_i;
  logic                xr0_i;
  logic                ern_i;
  logic                isp_i;
  logic                efl_i;
  // pipeline control
  logic                stall;
  logic                flush;
  // stage-4 strobes
  logic                out_valid;
  logic                wr;
  logic                lrn;
  logic                lr0;
  logic                ern;
  logic                lsp;
  logic                dsp;
  logic                lop;
  logic                efl;
  logic                taken;
  logic                squash_active;

  modport master (
    output in_valid, opcode, flags, wr_i, xrn_i, xr0_i, ern_i, isp_i, efl_i,
           stall, flush,
    input  out_valid, wr, lrn, lr0, ern, lsp, dsp, lop, efl, taken,
           squash_active
  );

  modport slave (
    input  in_valid, opcode, flags, wr_i, xrn_i, xr0_i, ern_i, isp_i, efl_i,
           stall, flush,
    output out_valid, wr, lrn, lr0, ern, lsp, dsp, lop, efl, taken,
           squash_active
  );
endinterface

// File: rtl/ctrl_code_gen_s4.sv
// ---------------------------------------------------------------------------
// ctrl_code_gen_s4
// Fourth-stage control code generator. Registers the stage-3 slot, decodes
// the stack / output / flag-enable strobes from the held opcode and evaluates
// the selected condition flag; a failed conditional suppresses its write and
// turns its stack push into the isp-driven decrement.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - ctrl_code_gen_s4_if.slave (slot in, stall/flush, strobes out)
//
// Parameters:
//   FLAG_CNT     - width of the flag vector, opcode[2:0] selects the flag
//   SQUASH_DEPTH - younger slots killed after a taken transfer (1..7)
//
// Build option: define CCG4_SQUASH_EN to build the squash sequencer.
// Without it squash_active is tied low and killing is left upstream.
// ---------------------------------------------------------------------------
module ctrl_code_gen_s4 #(
  parameter int FLAG_CNT     = 8,
  parameter int SQUASH_DEPTH = 2
) (
  input logic              clk,
  input logic              rst_n,
  ctrl_code_gen_s4_if.slave bus
);

  localparam int SEL_CNT = (FLAG_CNT < 8) ? FLAG_CNT : 8;

  // Flag-enable decode; the same opcode groups are conditional transfers.
  function automatic logic dec_efl(input logic [7:0] op);
    case (op[7:3])
      5'b00001, 5'b00101, 5'b00110, 5'b00111, 5'b01001: dec_efl = 1'b1;
      default:                                          dec_efl = 1'b0;
    endcase
  endfunction

  function automatic logic dec_dsp(input logic [7:0] op);
    case (op)
      8'h05, 8'h06: dec_dsp = 1'b1;
      default:      dec_dsp = (op[7:4] == 4'h3) || (op[7:3] == 5'b01101);
    endcase
  endfunction

  function automatic logic dec_xfer(input logic [7:0] op);
    dec_xfer = ((op >= 8'h03) && (op <= 8'h07)) || dec_efl(op);
  endfunction

  logic       fl_s;
  logic       capt_valid_s;
  logic       efl_dec_s;
  logic       cf_s;
  logic       efl_unused_s;
  logic       valid_r;
  logic [7:0] op_r;
  logic       fl_r;
  logic       wr_r;
  logic       xrn_r;
  logic       xr0_r;
  logic       ern_r;
  logic       isp_r;
  logic       efl_r;

  // Flag select; indices beyond the flag vector read as 0.
  always_comb begin
    fl_s = 1'b0;
    for (int i = 0; i < SEL_CNT; i++) begin
      fl_s = (bus.opcode[2:0] == 3'(i)) ? bus.flags[i] : fl_s;
    end
  end

`ifdef CCG4_SQUASH_EN
  typedef enum logic {IDLE = 1'b0, SQUASH = 1'b1} sq_state_t;

  sq_state_t  state_r;
  sq_state_t  state_n;
  logic [2:0] sq_cnt_r;
  logic [2:0] sq_cnt_n;
  logic       in_taken_s;

  // The sequencer arms on the edge that captures the committing transfer,
  // so taken and squash_active rise together and the very next accepted
  // slot is the first kill.
  assign in_taken_s   = bus.in_valid & dec_xfer(bus.opcode) &
                        ~(dec_efl(bus.opcode) & ~fl_s);
  assign capt_valid_s = bus.in_valid & (state_r == IDLE);

  // Squash next-state and kill counter.
  always_comb begin
    state_n  = state_r;
    sq_cnt_n = sq_cnt_r;
    if (bus.flush) begin
      state_n  = IDLE;
      sq_cnt_n = 3'd0;
    end else if (bus.stall) begin
      state_n  = state_r;
      sq_cnt_n = sq_cnt_r;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_taken_s) begin
            state_n  = SQUASH;
            sq_cnt_n = 3'(SQUASH_DEPTH);
          end else begin
            state_n  = IDLE;
            sq_cnt_n = 3'd0;
          end
        end
        SQUASH: begin
          if (sq_cnt_r == 3'd1) begin
            state_n  = IDLE;
            sq_cnt_n = 3'd0;
          end else begin
            state_n  = SQUASH;
            sq_cnt_n = sq_cnt_r - 3'd1;
          end
        end
        default: begin
          state_n  = IDLE;
          sq_cnt_n = 3'd0;
        end
      endcase
    end
  end

  // Squash state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      sq_cnt_r <= 3'd0;
    end else begin
      state_r  <= state_n;
      sq_cnt_r <= sq_cnt_n;
    end
  end

  assign bus.squash_active = (state_r == SQUASH);
`else
  localparam int depth_unused = SQUASH_DEPTH;

  assign capt_valid_s      = bus.in_valid;
  assign bus.squash_active = 1'b0;
`endif

  // Stage register; flush kills the slot even while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      op_r    <= 8'h00;
      fl_r    <= 1'b0;
      wr_r    <= 1'b0;
      xrn_r   <= 1'b0;
      xr0_r   <= 1'b0;
      ern_r   <= 1'b0;
      isp_r   <= 1'b0;
      efl_r   <= 1'b0;
    end else begin
      if (bus.flush) begin
        valid_r <= 1'b0;
      end else if (!bus.stall) begin
        valid_r <= capt_valid_s;
      end
      if (!bus.stall) begin
        op_r  <= bus.opcode;
        fl_r  <= fl_s;
        wr_r  <= bus.wr_i;
        xrn_r <= bus.xrn_i;
        xr0_r <= bus.xr0_i;
        ern_r <= bus.ern_i;
        isp_r <= bus.isp_i;
        efl_r <= bus.efl_i;
      end
    end
  end

  // The stage-3 flag-enable is held with the slot, but the strobe itself
  // comes from the stage-4 decode.
  assign efl_unused_s = efl_r;

  assign efl_dec_s = dec_efl(op_r);
  assign cf_s      = efl_dec_s & ~fl_r;

  assign bus.out_valid = valid_r;
  assign bus.wr        = valid_r & wr_r & ~cf_s;
  assign bus.lrn       = valid_r & xrn_r;
  assign bus.lr0       = valid_r & xr0_r;
  assign bus.ern       = valid_r & ern_r;
  assign bus.lsp       = valid_r & (op_r == 8'h10);
  // A failed conditional call does not push; isp then requests the decrement.
  assign bus.dsp       = valid_r & ((isp_r & cf_s) | (dec_dsp(op_r) & ~cf_s));
  assign bus.lop       = valid_r & (op_r[7:3] == 5'b11111);
  assign bus.efl       = valid_r & efl_dec_s;
  assign bus.taken     = valid_r & dec_xfer(op_r) & ~cf_s;

endmodule

// File: tb/tb_ctrl_code_gen_s4.sv
module tb_ctrl_code_gen_s4;

`ifdef CCG4_SQUASH_EN
  localparam bit SQ = 1'b1;
`else
  localparam bit SQ = 1'b0;
`endif

  // Output vector bit positions
  localparam logic [10:0] OV  = 11'h400;
  localparam logic [10:0] WR  = 11'h200;
  localparam logic [10:0] LRN = 11'h100;
  localparam logic [10:0] LR0 = 11'h080;
  localparam logic [10:0] ERN = 11'h040;
  localparam logic [10:0] LSP = 11'h020;
  localparam logic [10:0] DSP = 11'h010;
  localparam logic [10:0] LOP = 11'h008;
  localparam logic [10:0] EFL = 11'h004;
  localparam logic [10:0] TKN = 11'h002;
  localparam logic [10:0] SA  = 11'h001;
  localparam logic [10:0] NONE = 11'h000;
  // squash_active where the sequencer exists
  localparam logic [10:0] SAE   = SQ ? SA : NONE;
  // a 0xF8 slot that is the first / second kill after a transfer
  localparam logic [10:0] KILL1 = SQ ? SA : (OV | LOP);
  localparam logic [10:0] KILL2 = SQ ? NONE : (OV | LOP);

  typedef struct {
    string       name;
    bit          dut;
    logic [10:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  chk_cnt  = 0;
  int  pass_cnt = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  ctrl_code_gen_s4_if #(.FLAG_CNT(8)) bus0();
  ctrl_code_gen_s4_if #(.FLAG_CNT(4)) bus1();

  ctrl_code_gen_s4 #(.FLAG_CNT(8), .SQUASH_DEPTH(2)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  ctrl_code_gen_s4 #(.FLAG_CNT(4), .SQUASH_DEPTH(2)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  logic [10:0] o0;
  logic [10:0] o1;
  assign o0 = {bus0.out_valid, bus0.wr, bus0.lrn, bus0.lr0, bus0.ern, bus0.lsp,
               bus0.dsp, bus0.lop, bus0.efl, bus0.taken, bus0.squash_active};
  assign o1 = {bus1.out_valid, bus1.wr, bus1.lrn, bus1.lr0, bus1.ern, bus1.lsp,
               bus1.dsp, bus1.lop, bus1.efl, bus1.taken, bus1.squash_active};

  task automatic idle_inputs();
    bus0.in_valid = 1'b0; bus0.opcode = 8'h00; bus0.flags = 8'h00;
    {bus0.wr_i, bus0.xrn_i, bus0.xr0_i, bus0.ern_i, bus0.isp_i, bus0.efl_i} = 6'b0;
    bus0.stall = 1'b0; bus0.flush = 1'b0;
    bus1.in_valid = 1'b0; bus1.opcode = 8'h00; bus1.flags = 4'h0;
    {bus1.wr_i, bus1.xrn_i, bus1.xr0_i, bus1.ern_i, bus1.isp_i, bus1.efl_i} = 6'b0;
    bus1.stall = 1'b0; bus1.flush = 1'b0;
  endtask

  // ctl = {wr_i, xrn_i, xr0_i, ern_i, isp_i, efl_i}
  task automatic step(input bit d, input logic iv, input logic [7:0] op,
                      input logic [7:0] fl, input logic [5:0] ctl,
                      input logic st, input logic fs,
                      input logic [10:0] e, input string nm);
    @(negedge clk);
    idle_inputs();
    if (d == 1'b0) begin
      bus0.in_valid = iv; bus0.opcode = op; bus0.flags = fl;
      {bus0.wr_i, bus0.xrn_i, bus0.xr0_i, bus0.ern_i, bus0.isp_i, bus0.efl_i} = ctl;
      bus0.stall = st; bus0.flush = fs;
    end else begin
      bus1.in_valid = iv; bus1.opcode = op; bus1.flags = fl[3:0];
      {bus1.wr_i, bus1.xrn_i, bus1.xr0_i, bus1.ern_i, bus1.isp_i, bus1.efl_i} = ctl;
      bus1.stall = st; bus1.flush = fs;
    end
    sb_q.push_back('{nm, d, e});
  endtask

  task automatic direct_check(input logic [10:0] got, input logic [10:0] e,
                              input string nm);
    chk_cnt++;
    if (got === e) pass_cnt++;
    else $display("FAIL %s got=%b exp=%b", nm, got, e);
  endtask

  // Monitor: one expectation per accepted edge, compared just after the edge.
  always begin
    sb_t ent;
    logic [10:0] got;
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      ent = sb_q.pop_front();
      got = ent.dut ? o1 : o0;
      chk_cnt++;
      if (got === ent.exp) pass_cnt++;
      else $display("FAIL %s dut%0d got=%b exp=%b", ent.name, ent.dut, got, ent.exp);
    end
  end

  initial begin
    idle_inputs();
    repeat (2) @(negedge clk);
    direct_check(o0, NONE, "reset_dut0");
    direct_check(o1, NONE, "reset_dut1");
    rst_n = 1'b1;

    step(0, 1'b0, 8'h00, 8'hFF, 6'b000000, 0, 0, NONE,                  "idle_slot");
    step(0, 1'b1, 8'h33, 8'hF7, 6'b100010, 0, 0, OV|DSP|EFL,            "call_fail");
    step(0, 1'b1, 8'h33, 8'hFF, 6'b100010, 0, 0, OV|WR|DSP|EFL|TKN|SAE, "call_pass");
    step(0, 1'b0, 8'h00, 8'h00, 6'b000000, 0, 0, SAE,                   "bubble_kill1");
    step(0, 1'b0, 8'h00, 8'h00, 6'b000000, 0, 0, NONE,                  "bubble_kill2");
    step(0, 1'b1, 8'h10, 8'h00, 6'b011000, 0, 0, OV|LRN|LR0|LSP,        "lsp_lrn_lr0");
    step(0, 1'b1, 8'h6A, 8'h00, 6'b100100, 0, 0, OV|WR|ERN|DSP,         "dsp_6a");
    step(0, 1'b1, 8'h0D, 8'hDF, 6'b000000, 0, 0, OV|EFL,                "cond_flag5_clr");

    // squash window
    step(0, 1'b1, 8'h03, 8'h00, 6'b000000, 0, 0, OV|TKN|SAE,            "jud_03");
    step(0, 1'b1, 8'hF8, 8'h00, 6'b000000, 0, 0, KILL1,                 "win_slot1");
    step(0, 1'b1, 8'hF8, 8'h00, 6'b000000, 0, 0, KILL2,                 "win_slot2");
    step(0, 1'b1, 8'hF8, 8'h00, 6'b000000, 0, 0, OV|LOP,                "win_slot3");

    // stall during squash; flags change while held
    step(0, 1'b1, 8'h4B, 8'hFF, 6'b000000, 0, 0, OV|EFL|TKN|SAE,        "xfer_4b");
    for (int i = 0; i < 3; i++)
      step(0, 1'b1, 8'hF8, 8'h00, 6'b000000, 1, 0, OV|EFL|TKN|SAE,      "stall_hold");
    step(0, 1'b1, 8'hF8, 8'hFF, 6'b000000, 0, 0, KILL1,                 "post_stall1");
    step(0, 1'b1, 8'hF8, 8'hFF, 6'b000000, 0, 0, KILL2,                 "post_stall2");
    step(0, 1'b1, 8'hF8, 8'hFF, 6'b000000, 0, 0, OV|LOP,                "post_stall3");

    // flush
    step(0, 1'b1, 8'h04, 8'h00, 6'b000000, 0, 1, NONE,                  "flush_04");
    step(0, 1'b1, 8'hF8, 8'h00, 6'b000000, 0, 0, OV|LOP,                "after_flush");
    step(0, 1'b1, 8'h03, 8'h00, 6'b000000, 0, 0, OV|TKN|SAE,            "jud_03_b");
    step(0, 1'b1, 8'hF8, 8'h00, 6'b000000, 0, 1, NONE,                  "flush_in_squash");
    step(0, 1'b1, 8'hF8, 8'h00, 6'b000000, 0, 0, OV|LOP,                "after_flush2");

    // reset mid-squash
    step(0, 1'b1, 8'h03, 8'h00, 6'b000000, 0, 0, OV|TKN|SAE,            "jud_03_c");
    step(0, 1'b1, 8'hF8, 8'h00, 6'b000000, 0, 0, KILL1,                 "pre_reset");
    @(negedge clk);
    idle_inputs();
    #1 rst_n = 1'b0;
    #1 direct_check(o0, NONE, "async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1'b1, 8'h20, 8'h00, 6'b000100, 0, 0, OV|ERN,                "ern_after_rst");

    // FLAG_CNT = 4 instance
    step(1, 1'b1, 8'h0E, 8'h0F, 6'b000000, 0, 0, OV|EFL,                "flag_oob");
    step(1, 1'b1, 8'h0A, 8'h04, 6'b000000, 0, 0, OV|EFL|TKN|SAE,        "flag2_set");

    @(negedge clk);
    idle_inputs();
    repeat (3) @(posedge clk);
    #2;
    chk_cnt++;
    if (sb_q.size() == 0) pass_cnt++;
    else $display("FAIL scoreboard_drain left=%0d", sb_q.size());

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
